demux_lane_arbiter: RTL and testbench

- Round-robin arbiter/scheduler that shares the single 8-bit `valid`/`data_in` input path of the layer-2 byte demux between four upstream byte sources.
- Grants one requester at a time and forwards its bytes as a registered `valid_out`/`data_out` stream into the demux.
- Honours downstream back-pressure.
- Sits directly in front of the demux, in the demux's fastest clock domain.

---
 rtl/demux_lane_arbiter_if.sv | 18 +
 rtl/demux_lane_arbiter.sv | 66 ++++++
 tb/tb_demux_lane_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/demux_lane_arbiter_if.sv
// demux_lane_arbiter_if: four byte sources, demux back-pressure and the registered grant/byte stream
interface demux_lane_arbiter_if #(parameter int DATA_W = 8);
  logic [3:0]        req;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic [DATA_W-1:0] data_3;
  logic              ready_in;
  logic [3:0]        gnt;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        active_lane;
  logic              idle;
  modport master (output req, data_0, data_1, data_2, data_3, ready_in,
                  input gnt, valid_out, data_out, active_lane, idle);
  modport slave (input req, data_0, data_1, data_2, data_3, ready_in,
                 output gnt, valid_out, data_out, active_lane, idle);
endinterface

// File: rtl/demux_lane_arbiter.sv
// demux_lane_arbiter: round-robin share of the demux byte input among four sources
// DEMUX_ARB_BURST_HOLD_EN: hold a grant for up to MAX_BURST accepted bytes
module demux_lane_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  reset_L,
  demux_lane_arbiter_if.slave  bus
);
`ifdef DEMUX_ARB_BURST_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            state, state_d;
  logic [1:0]        ptr, ptr_d, win, lane_d;
  logic [3:0]        cnt, cnt_d, gnt_d;
  logic              valid_d, acc, rel;
  logic [DATA_W-1:0] din, data_d;
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (bus.req[ptr + 2'(k)]) win = ptr + 2'(k);
  end
  assign din = bus.active_lane == 2'd0 ? bus.data_0 :
               bus.active_lane == 2'd1 ? bus.data_1 :
               bus.active_lane == 2'd2 ? bus.data_2 : bus.data_3;
  assign acc = state == GRANT && bus.req[bus.active_lane] && bus.ready_in;
  // without burst hold every acceptance ends the grant
  assign rel = state == GRANT && (!bus.req[bus.active_lane] || (acc && (!HOLD || cnt == LAST)));
  assign bus.idle = state == IDLE;
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state           <= IDLE;
      ptr             <= 2'd0;
      cnt             <= 4'd0;
      bus.gnt         <= 4'd0;
      bus.valid_out   <= 1'b0;
      bus.data_out    <= '0;
      bus.active_lane <= 2'd0;
    end else begin
      state           <= state_d;
      ptr             <= ptr_d;
      cnt             <= cnt_d;
      bus.gnt         <= gnt_d;
      bus.valid_out   <= valid_d;
      bus.data_out    <= data_d;
      bus.active_lane <= lane_d;
    end
  end
  always_comb begin
    state_d = state == IDLE ? (|bus.req ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end
  always_comb begin
    gnt_d   = state == IDLE ? (|bus.req ? 4'd1 << win : 4'd0) : (rel ? 4'd0 : bus.gnt);
    lane_d  = state == IDLE && |bus.req ? win : bus.active_lane;
    cnt_d   = state == IDLE ? 4'd0 : (acc ? cnt + 4'd1 : cnt);
    ptr_d   = rel ? bus.active_lane + 2'd1 : ptr;
    // a presented byte is consumed whenever ready_in is high
    valid_d = acc ? 1'b1 : (bus.ready_in ? 1'b0 : bus.valid_out);
    data_d  = acc ? din : bus.data_out;
  end
endmodule

// File: tb/tb_demux_lane_arbiter.sv
// tb_demux_lane_arbiter: directed checks of arbitration, bursts, back-pressure and reset
module tb_demux_lane_arbiter;
`ifdef DEMUX_ARB_BURST_HOLD_EN
  localparam int BURST = 4;
`else
  localparam int BURST = 1;
`endif
  logic clk, reset_L;
  int errors = 0;
  int checks = 0;
  logic [7:0] ld [4];
  logic [7:0] sb [5];
  demux_lane_arbiter_if #(.DATA_W(8)) bus();
  demux_lane_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    ld[0] = 8'h99; ld[1] = 8'hAA; ld[2] = 8'h88; ld[3] = 8'h77;
    sb[0] = 8'hFF; sb[1] = 8'hDD; sb[2] = 8'hEE; sb[3] = 8'hCC; sb[4] = 8'hBB;
    reset_L = 1'b0;
    bus.req = 4'hF;
    bus.ready_in = 1'b1;
    bus.data_0 = ld[0]; bus.data_1 = ld[1]; bus.data_2 = ld[2]; bus.data_3 = ld[3];
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_idle", 32'(bus.idle), 1);
    chk("rst_lane", 32'(bus.active_lane), 0);
    reset_L = 1'b1;
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("cont_gnt", 32'(bus.gnt), 32'(1) << (r % 4));
      chk("cont_gvalid", 32'(bus.valid_out), 0);
      chk("cont_lane", 32'(bus.active_lane), r % 4);
      for (int b = 0; b < BURST; b++) begin
        tick();
        chk("cont_valid", 32'(bus.valid_out), 1);
        chk("cont_data", 32'(bus.data_out), 32'(ld[r % 4]));
        chk("cont_hold", 32'(bus.gnt), b == BURST - 1 ? 0 : 32'(1) << (r % 4));
      end
    end
    bus.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      if (i % BURST == 0) begin
        tick();
        chk("single_gnt", 32'(bus.gnt), 4'b0100);
        chk("single_gvalid", 32'(bus.valid_out), 0);
      end
      bus.data_2 = sb[i];
      tick();
      chk("single_valid", 32'(bus.valid_out), 1);
      chk("single_data", 32'(bus.data_out), 32'(sb[i]));
      chk("single_hold", 32'(bus.gnt), i % BURST == BURST - 1 ? 0 : 4'b0100);
    end
    bus.req = 4'b0000;
    tick();
    chk("drop_gnt", 32'(bus.gnt), 0);
    chk("drop_valid", 32'(bus.valid_out), 0);
    chk("drop_idle", 32'(bus.idle), 1);
    bus.req = 4'b0010;
    bus.data_1 = 8'hAA;
    bus.ready_in = 1'b0;
    tick();
    chk("bp_gnt", 32'(bus.gnt), 4'b0010);
    chk("bp_lane", 32'(bus.active_lane), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_gnt", 32'(bus.gnt), 4'b0010);
      chk("bp_hold_valid", 32'(bus.valid_out), 0);
      chk("bp_hold_data", 32'(bus.data_out), 8'hBB);
    end
    bus.ready_in = 1'b1;
    tick();
    chk("bp_valid", 32'(bus.valid_out), 1);
    chk("bp_data", 32'(bus.data_out), 8'hAA);
    chk("bp_gnt_after", 32'(bus.gnt), BURST == 1 ? 0 : 4'b0010);
    bus.req = 4'b0000;
    tick();
    chk("bp_once", 32'(bus.valid_out), 0);
    chk("bp_rel", 32'(bus.gnt), 0);
    bus.req = 4'b1000;
    bus.data_3 = 8'h88;
    tick();
    chk("own_gnt", 32'(bus.gnt), 4'b1000);
    bus.req = 4'b1010;
    tick();
    chk("own_valid", 32'(bus.valid_out), 1);
    chk("own_data", 32'(bus.data_out), 8'h88);
    chk("own_gnt_after", 32'(bus.gnt), BURST == 1 ? 0 : 4'b1000);
`ifdef DEMUX_ARB_BURST_HOLD_EN
    bus.req = 4'b0010;
    tick();
    chk("own_rel", 32'(bus.gnt), 0);
    chk("own_rel_valid", 32'(bus.valid_out), 0);
    bus.req = 4'b1010;
`endif
    tick();
    chk("own_next_gnt", 32'(bus.gnt), 4'b0010);
    chk("own_next_lane", 32'(bus.active_lane), 1);
    bus.data_1 = 8'hEE;
    tick();
    chk("mid_valid", 32'(bus.valid_out), 1);
    chk("mid_data", 32'(bus.data_out), 8'hEE);
    #1 reset_L = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.valid_out), 0);
    chk("arst_data", 32'(bus.data_out), 0);
    chk("arst_gnt", 32'(bus.gnt), 0);
    chk("arst_idle", 32'(bus.idle), 1);
    chk("arst_lane", 32'(bus.active_lane), 0);
    #1 reset_L = 1'b1;
    tick();
    chk("post_gnt", 32'(bus.gnt), 4'b0010);
    chk("post_valid", 32'(bus.valid_out), 0);
    tick();
    chk("post_byte_valid", 32'(bus.valid_out), 1);
    chk("post_byte_data", 32'(bus.data_out), 8'hEE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
